// File: rtl/l2_mem_pkg.sv
// l2_mem_pkg: shared types and constants for the L2 memory-side controller.
//   - l2_state_e      : controller FSM states
//   - L2_* localparams: default geometry (32-bit words, 64 B lines)
//   - line_base()     : clears the in-line offset bits of a byte address
package l2_mem_pkg;

   localparam int L2_DATA_LENGTH    = 32;
   localparam int L2_LINE_SIZE      = 64;
   localparam int L2_ADDR_WIDTH     = 32;
   localparam int L2_WORDS_PER_LINE = L2_LINE_SIZE / 4;
   localparam int L2_OFFSET_BITS    = $clog2(L2_LINE_SIZE);
   // Widest address line_base() handles; callers cast in and out.
   localparam int L2_MAX_ADDR_W     = 64;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WB,
      ST_WB_DONE,
      ST_RF,
      ST_RF_DONE
   } l2_state_e;

   function automatic logic [L2_MAX_ADDR_W-1:0] line_base(
      input logic [L2_MAX_ADDR_W-1:0] addr,
      input int unsigned              off_bits
   );
      return addr & ({L2_MAX_ADDR_W{1'b1}} << off_bits);
   endfunction

endpackage

// File: rtl/l2_wb_line_buffer.sv
// l2_wb_line_buffer: holds the dirty line captured at writeback acceptance and
// presents the selected word to the memory bus.
//   clk, rst  : clock, synchronous active-high reset (clears the line)
//   load      : capture line_in this cycle
//   line_in   : full line, word w at bits [(w+1)*DATA_LENGTH-1 : w*DATA_LENGTH]
//   sel       : word index to present
//   word_out  : selected word of the latched line
module l2_wb_line_buffer
   import l2_mem_pkg::*;
#(
   parameter int DATA_LENGTH = L2_DATA_LENGTH,
   parameter int WORDS       = L2_WORDS_PER_LINE,
   parameter int IDX_W       = $clog2(WORDS)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         load,
   input  logic [WORDS*DATA_LENGTH-1:0] line_in,
   input  logic [IDX_W-1:0]             sel,
   output logic [DATA_LENGTH-1:0]       word_out
);

   logic [WORDS-1:0][DATA_LENGTH-1:0] line_q, line_d;

   always_comb begin
      line_d = line_q;
      if (load) line_d = line_in;
   end

   always_ff @(posedge clk) begin
      if (rst) line_q <= '0;
      else     line_q <= line_d;
   end

   assign word_out = line_q[sel];

endmodule

// File: rtl/l2_mem_controller.sv
// l2_mem_controller: turns L2 line writebacks and line refills into single-word
// memory bus transactions. Writeback wins when both requests are pending.
//   clk, rst                  : clock, synchronous active-high reset
//   refill_req/refill_addr    : line refill request (level) and miss address
//   mem_refill_valid/_data    : refill word stream back to the cache
//   refill_word_idx/refill_last: index of the current refill word, final-word flag
//   writeback_req/_addr/_data : dirty line writeback request (level)
//   writeback_done            : one-cycle pulse after the last word is written
//   mem_req/_we/_addr/_wdata  : memory bus request; held until mem_ack
//   mem_ack/mem_rdata         : bus completion and read data
// Optional feature: define L2_MEM_CRITICAL_WORD_FIRST_EN to start refills at
// the missing word and wrap around the line.
module l2_mem_controller
   import l2_mem_pkg::*;
#(
   parameter int DATA_LENGTH = L2_DATA_LENGTH,
   parameter int LINE_SIZE   = L2_LINE_SIZE,
   parameter int ADDR_WIDTH  = L2_ADDR_WIDTH,
   localparam int WPL        = LINE_SIZE / 4,
   localparam int IDX_W      = $clog2(WPL)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     refill_req,
   input  logic [ADDR_WIDTH-1:0]    refill_addr,
   output logic                     mem_refill_valid,
   output logic [DATA_LENGTH-1:0]   mem_refill_data,
   output logic [IDX_W-1:0]         refill_word_idx,
   output logic                     refill_last,
   input  logic                     writeback_req,
   input  logic [ADDR_WIDTH-1:0]    writeback_addr,
   input  logic [LINE_SIZE*8-1:0]   writeback_data,
   output logic                     writeback_done,
   output logic                     mem_req,
   output logic                     mem_we,
   output logic [ADDR_WIDTH-1:0]    mem_addr,
   output logic [DATA_LENGTH-1:0]   mem_wdata,
   input  logic                     mem_ack,
   input  logic [DATA_LENGTH-1:0]   mem_rdata
);

   localparam int OFF_BITS = $clog2(LINE_SIZE);

   l2_state_e               state_q, state_d;
   logic [IDX_W-1:0]        cnt_q, cnt_d;       // words completed in this line
   logic [IDX_W-1:0]        start_q, start_d;   // first word index (0 unless critical-word-first)
   logic [ADDR_WIDTH-1:0]   base_q, base_d;
   logic                    rf_valid_q, rf_valid_d;
   logic [DATA_LENGTH-1:0]  rf_data_q, rf_data_d;
   logic [IDX_W-1:0]        rf_idx_q, rf_idx_d;
   logic                    rf_last_q, rf_last_d;

   logic                    buf_load;
   logic [DATA_LENGTH-1:0]  buf_word;
   logic [IDX_W-1:0]        idx;
   logic [ADDR_WIDTH-1:0]   word_addr;
   logic                    last_word;

   // IDX_W-bit addition wraps modulo WPL, keeping the address inside the line.
   assign idx       = start_q + cnt_q;
   assign word_addr = base_q | ADDR_WIDTH'({idx, 2'b00});
   assign last_word = (cnt_q == IDX_W'(WPL - 1));

   l2_wb_line_buffer #(
      .DATA_LENGTH (DATA_LENGTH),
      .WORDS       (WPL),
      .IDX_W       (IDX_W)
   ) u_wb_buf (
      .clk      (clk),
      .rst      (rst),
      .load     (buf_load),
      .line_in  (writeback_data),
      .sel      (cnt_q),
      .word_out (buf_word)
   );

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      start_d        = start_q;
      base_d         = base_q;
      rf_valid_d     = 1'b0;
      rf_data_d      = '0;
      rf_idx_d       = '0;
      rf_last_d      = 1'b0;
      buf_load       = 1'b0;
      mem_req        = 1'b0;
      mem_we         = 1'b0;
      mem_addr       = '0;
      mem_wdata      = '0;
      writeback_done = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (writeback_req) begin
               buf_load = 1'b1;
               base_d   = ADDR_WIDTH'(line_base(L2_MAX_ADDR_W'(writeback_addr), OFF_BITS));
               cnt_d    = '0;
               start_d  = '0;
               state_d  = ST_WB;
            end else if (refill_req) begin
               base_d  = ADDR_WIDTH'(line_base(L2_MAX_ADDR_W'(refill_addr), OFF_BITS));
               cnt_d   = '0;
`ifdef L2_MEM_CRITICAL_WORD_FIRST_EN
               start_d = refill_addr[OFF_BITS-1:2];
`else
               start_d = '0;
`endif
               state_d = ST_RF;
            end
         end
         ST_WB: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = word_addr;
            mem_wdata = buf_word;
            if (mem_ack) begin
               cnt_d = cnt_q + IDX_W'(1);
               if (last_word) state_d = ST_WB_DONE;
            end
         end
         ST_WB_DONE: begin
            writeback_done = 1'b1;
            state_d        = ST_IDLE;
         end
         ST_RF: begin
            mem_req  = 1'b1;
            mem_addr = word_addr;
            if (mem_ack) begin
               rf_valid_d = 1'b1;
               rf_data_d  = mem_rdata;
               rf_idx_d   = idx;
               rf_last_d  = last_word;
               cnt_d      = cnt_q + IDX_W'(1);
               if (last_word) state_d = ST_RF_DONE;
            end
         end
         // One dead cycle so the cache has dropped refill_req before IDLE looks again.
         ST_RF_DONE: state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         start_q    <= '0;
         base_q     <= '0;
         rf_valid_q <= 1'b0;
         rf_data_q  <= '0;
         rf_idx_q   <= '0;
         rf_last_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         start_q    <= start_d;
         base_q     <= base_d;
         rf_valid_q <= rf_valid_d;
         rf_data_q  <= rf_data_d;
         rf_idx_q   <= rf_idx_d;
         rf_last_q  <= rf_last_d;
      end
   end

   assign mem_refill_valid = rf_valid_q;
   assign mem_refill_data  = rf_data_q;
   assign refill_word_idx  = rf_idx_q;
   assign refill_last      = rf_last_q;

endmodule

// File: tb/tb_l2_mem_controller.sv
// tb_l2_mem_controller: randomized bench for l2_mem_controller (64 B lines).
// A transaction-level model queues the bus transfers each accepted request must
// produce; a negedge monitor checks every bus cycle, refill word and done pulse.
module tb_l2_mem_controller;

   localparam int WPL = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic         refill_req;
   logic [31:0]  refill_addr;
   logic         mem_refill_valid;
   logic [31:0]  mem_refill_data;
   logic [3:0]   refill_word_idx;
   logic         refill_last;
   logic         writeback_req;
   logic [31:0]  writeback_addr;
   logic [511:0] writeback_data;
   logic         writeback_done;
   logic         mem_req;
   logic         mem_we;
   logic [31:0]  mem_addr;
   logic [31:0]  mem_wdata;
   logic         mem_ack;
   logic [31:0]  mem_rdata;

   l2_mem_controller dut (
      .clk              (clk),
      .rst              (rst),
      .refill_req       (refill_req),
      .refill_addr      (refill_addr),
      .mem_refill_valid (mem_refill_valid),
      .mem_refill_data  (mem_refill_data),
      .refill_word_idx  (refill_word_idx),
      .refill_last      (refill_last),
      .writeback_req    (writeback_req),
      .writeback_addr   (writeback_addr),
      .writeback_data   (writeback_data),
      .writeback_done   (writeback_done),
      .mem_req          (mem_req),
      .mem_we           (mem_we),
      .mem_addr         (mem_addr),
      .mem_wdata        (mem_wdata),
      .mem_ack          (mem_ack),
      .mem_rdata        (mem_rdata)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;
   int ack_mode = 3;   // 0: always, 1: every 3rd cycle, 2: random, 3: never

   typedef struct {
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          idx;
      bit          last;
   } xact_t;

   xact_t exp_q[$];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // ---------------- reference model: expected bus transfers ----------------
   task automatic push_wb(input logic [31:0] addr, input logic [511:0] line);
      xact_t e;
      logic [31:0] base;
      base = addr & ~32'h3F;
      for (int i = 0; i < WPL; i++) begin
         e.we = 1'b1; e.addr = base + 32'(4 * i); e.wdata = line[i*32 +: 32];
         e.idx = i; e.last = (i == WPL - 1);
         exp_q.push_back(e);
      end
   endtask

   task automatic push_rf(input logic [31:0] addr);
      xact_t e;
      logic [31:0] base;
      int start, w;
      base = addr & ~32'h3F;
`ifdef L2_MEM_CRITICAL_WORD_FIRST_EN
      start = int'((addr >> 2) % 16);
`else
      start = 0;
`endif
      for (int i = 0; i < WPL; i++) begin
         w = (start + i) % WPL;
         e.we = 1'b0; e.addr = base + 32'(4 * w); e.wdata = '0;
         e.idx = w; e.last = (i == WPL - 1);
         exp_q.push_back(e);
      end
   endtask

   // ---------------- memory bus responder ----------------
   initial begin
      mem_ack = 1'b0; mem_rdata = '0;
      forever begin
         @(posedge clk); cyc++; #1;
         case (ack_mode)
            0:       mem_ack = 1'b1;
            1:       mem_ack = (cyc % 3 == 0);
            2:       mem_ack = 1'($urandom_range(0, 1));
            default: mem_ack = 1'b0;
         endcase
         mem_rdata = $urandom;
      end
   end

   // ---------------- monitor ----------------
   initial begin
      xact_t e;
      bit pend_v, done_due;
      logic [31:0] pend_data;
      int pend_idx;
      bit pend_last;
      pend_v = 0; done_due = 0; pend_data = '0; pend_idx = 0; pend_last = 0;
      forever begin
         @(negedge clk);
         chk("rf_valid", 64'(mem_refill_valid), 64'(pend_v));
         if (pend_v) begin
            chk("rf_data", 64'(mem_refill_data), 64'(pend_data));
            chk("rf_idx",  64'(refill_word_idx), 64'(pend_idx));
            chk("rf_last", 64'(refill_last),     64'(pend_last));
         end else begin
            chk("rf_last_idle", 64'(refill_last), 64'd0);
         end
         chk("wb_done", 64'(writeback_done), 64'(done_due));
         pend_v = 0; done_due = 0;
         if (exp_q.size() == 0) begin
            chk("req_idle", 64'(mem_req), 64'd0);
         end else if (mem_req) begin
            chk("mem_we",   64'(mem_we),   64'(exp_q[0].we));
            chk("mem_addr", 64'(mem_addr), 64'(exp_q[0].addr));
            if (exp_q[0].we) chk("mem_wdata", 64'(mem_wdata), 64'(exp_q[0].wdata));
            if (mem_ack && !rst) begin
               e = exp_q.pop_front();
               if (!e.we) begin
                  pend_v = 1; pend_data = mem_rdata; pend_idx = e.idx; pend_last = e.last;
               end else if (e.last) begin
                  done_due = 1;
               end
            end
         end
         // Reset abandons whatever was in flight.
         if (rst) begin
            exp_q.delete(); pend_v = 0; done_due = 0;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic wait_wb_done(output int at);
      at = -1;
      for (int n = 0; n < 2000; n++) begin
         @(negedge clk);
         if (writeback_done) begin at = cyc; break; end
      end
      if (at < 0) chk("wb_timeout", 64'd0, 64'd1);
   endtask

   task automatic wait_rf_last();
      int seen;
      seen = 0;
      for (int n = 0; n < 2000; n++) begin
         @(negedge clk);
         if (refill_last) begin seen = 1; break; end
      end
      if (seen == 0) chk("rf_timeout", 64'd0, 64'd1);
   endtask

   function automatic logic [511:0] rand_line();
      logic [511:0] l;
      for (int i = 0; i < WPL; i++) l[i*32 +: 32] = $urandom;
      return l;
   endfunction

   task automatic do_wb(input logic [31:0] addr, input logic [511:0] line, input bit lat_chk);
      int c0, c1;
      @(posedge clk); #1;
      writeback_addr = addr; writeback_data = line; writeback_req = 1'b1;
      push_wb(addr, line);
      c0 = cyc;
      @(negedge clk);
      if (lat_chk) chk("req_pre_accept", 64'(mem_req), 64'd0);
      @(posedge clk); #1;
      // accepted at that edge: later input changes must not matter
      writeback_addr = $urandom; writeback_data = rand_line();
      if (lat_chk) begin
         @(negedge clk);
         chk("req_rise", 64'(mem_req), 64'd1);
      end
      wait_wb_done(c1);
      // accept cycle through done cycle spans 1+16+1 = 18 cycles
      if (lat_chk) chk("wb_latency", 64'(c1 - c0), 64'd17);
      @(posedge clk); #1;
      writeback_req = 1'b0;
   endtask

   task automatic do_rf(input logic [31:0] addr, input bit scramble);
      @(posedge clk); #1;
      refill_addr = addr; refill_req = 1'b1;
      push_rf(addr);
      if (scramble) begin
         @(posedge clk); #1;
         refill_addr = $urandom;
      end
      wait_rf_last();
      @(posedge clk); #1;
      refill_req = 1'b0;
   endtask

   task automatic do_both(input logic [31:0] wa, input logic [511:0] line, input logic [31:0] ra);
      int c1;
      @(posedge clk); #1;
      writeback_addr = wa; writeback_data = line; writeback_req = 1'b1;
      refill_addr = ra; refill_req = 1'b1;
      push_wb(wa, line);
      push_rf(ra);
      wait_wb_done(c1);
      @(posedge clk); #1;
      writeback_req = 1'b0;
      wait_rf_last();
      @(posedge clk); #1;
      refill_req = 1'b0;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [511:0] line;
      int n;
      rst = 1'b1;
      refill_req = 1'b0; refill_addr = '0;
      writeback_req = 1'b0; writeback_addr = '0; writeback_data = '0;
      ack_mode = 2;

      // Reset held with random inputs: every output stays 0.
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         refill_req = 1'($urandom); writeback_req = 1'($urandom);
         refill_addr = $urandom; writeback_addr = $urandom; writeback_data = rand_line();
         @(negedge clk);
         chk("rst_mem_req",   64'(mem_req),          64'd0);
         chk("rst_mem_we",    64'(mem_we),           64'd0);
         chk("rst_mem_addr",  64'(mem_addr),         64'd0);
         chk("rst_mem_wdata", 64'(mem_wdata),        64'd0);
         chk("rst_rf_valid",  64'(mem_refill_valid), 64'd0);
         chk("rst_rf_data",   64'(mem_refill_data),  64'd0);
         chk("rst_rf_idx",    64'(refill_word_idx),  64'd0);
         chk("rst_rf_last",   64'(refill_last),      64'd0);
         chk("rst_wb_done",   64'(writeback_done),   64'd0);
      end
      @(posedge clk); #1;
      refill_req = 1'b0; writeback_req = 1'b0; rst = 1'b0;
      repeat (3) @(posedge clk);

      // Zero-wait writeback at 0x1234: words 0x1200..0x123C, done 18 cycles on.
      ack_mode = 0;
      for (int i = 0; i < WPL; i++) line[i*32 +: 32] = 32'hA500_0000 + 32'(i);
      do_wb(32'h0000_1234, line, 1'b1);

      // Refill with ack every 3rd cycle.
      ack_mode = 1;
      do_rf(32'h0000_2000, 1'b1);

      // Simultaneous requests: writeback completes before any read.
      ack_mode = 2;
      do_both(32'h0000_5A10, rand_line(), 32'h0000_7F3C);

`ifdef L2_MEM_CRITICAL_WORD_FIRST_EN
      // Critical word first: order 9..15, 0..8.
      ack_mode = 0;
      do_rf(32'h0000_3024, 1'b0);
`endif

      // Reset after 5 refill acks, then a clean refill.
      ack_mode = 1;
      @(posedge clk); #1;
      refill_addr = 32'h0000_4440; refill_req = 1'b1;
      push_rf(32'h0000_4440);
      n = 0;
      for (int k = 0; k < 500 && n < 5; k++) begin
         @(negedge clk);
         if (mem_req && mem_ack) n++;
      end
      chk("mid_rst_acks", 64'(n), 64'd5);
      @(posedge clk); #1;
      rst = 1'b1; refill_req = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("mid_rst_req",   64'(mem_req),          64'd0);
      chk("mid_rst_last",  64'(refill_last),      64'd0);
      chk("mid_rst_valid", 64'(mem_refill_valid), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      ack_mode = 2;
      do_rf(32'h0000_4440, 1'b0);

      // Randomized mix.
      for (int it = 0; it < 24; it++) begin
         ack_mode = $urandom_range(0, 2);
         case ($urandom_range(0, 2))
            0:       do_wb($urandom, rand_line(), 1'b0);
            1:       do_rf($urandom, 1'b1);
            default: do_both($urandom, rand_line(), $urandom);
         endcase
         repeat ($urandom_range(0, 3)) @(posedge clk);
      end

      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, %0d failed so far", n_fail);
      $fatal(1);
   end

endmodule
